// File: rtl/clint_pkg.sv
// Shared CLINT definitions: response codes, register map, AXI encodings, FSM states.
// Pure declarations, no logic and no latency.
package clint_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] CLINT_BASE   = 32'h1001_0000;
    localparam logic [3:0]  OFF_MTIME_LO = 4'h0;
    localparam logic [3:0]  OFF_MTIME_HI = 4'h4;
    localparam logic [3:0]  OFF_CMP_LO   = 4'h8;
    localparam logic [3:0]  OFF_CMP_HI   = 4'hC;

    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_BEAT
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // The subtraction wraps for addresses below base, so one unsigned bound covers both sides.
    function automatic logic access_legal(input logic [31:0] base,
                                          input logic [31:0] addr,
                                          input logic [7:0]  len,
                                          input logic [2:0]  size,
                                          input logic [1:0]  burst);
        logic [31:0] off;
        off = addr - base;
        return (off <= {28'd0, OFF_CMP_HI}) && (off[1:0] == 2'b00) &&
               (len == 8'd0) && (size == SIZE_4B) && (burst == BURST_INCR);
    endfunction

    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// Prescaled 64-bit mtime, mtimecmp with byte-strobe word writes, registered irq compare.
// Write takes effect next clock; read data is combinational from current registers; no backpressure.
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_sel_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_strb_i,
    input  logic [1:0]  rd_sel_i,
    output logic [31:0] rd_data_o,
    output logic        timer_irq_o
);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        irq_q;
    logic        tick;

    assign tick    = (presc_q == 16'(TICK_DIV - 1));
    assign presc_d = tick ? 16'd0 : presc_q + 16'd1;

    // A software write to either mtime half replaces that cycle's increment.
    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d   = cmp_q;
        if (wr_en_i) begin
            case (wr_sel_i)
                2'd0: mtime_d = {mtime_q[63:32], merge_strb(mtime_q[31:0], wr_data_i, wr_strb_i)};
                2'd1: mtime_d = {merge_strb(mtime_q[63:32], wr_data_i, wr_strb_i), mtime_q[31:0]};
                2'd2: cmp_d   = {cmp_q[63:32], merge_strb(cmp_q[31:0], wr_data_i, wr_strb_i)};
                default: cmp_d = {merge_strb(cmp_q[63:32], wr_data_i, wr_strb_i), cmp_q[31:0]};
            endcase
        end
    end

    always_comb begin
        case (rd_sel_i)
            2'd0:    rd_data_o = mtime_q[31:0];
            2'd1:    rd_data_o = mtime_q[63:32];
            2'd2:    rd_data_o = cmp_q[31:0];
            default: rd_data_o = cmp_q[63:32];
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
            cmp_q   <= '1;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            irq_q   <= (mtime_d >= cmp_d);
        end
    end

    assign timer_irq_o = irq_q;

endmodule

// File: rtl/clint_axi_slave.sv
// AXI4 CLINT responder: single-beat word access to mtime/mtimecmp, SLVERR bursts for anything else.
// R beat one cycle after AR fire, B one cycle after wlast fire; R/B held stable until rready/bready.
module clint_axi_slave
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CLINT_BASE,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [3:0]  rid,
    output logic        rlast,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    output logic        timer_irq
);

    rd_state_e   r_state_q, r_state_d;
    logic [8:0]  beats_q, beats_d;
    logic        rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [3:0]  rid_q, rid_d;

    wr_state_e   w_state_q, w_state_d;
    logic [3:0]  awid_q, awid_d, bid_q, bid_d;
    logic [1:0]  wsel_q, wsel_d, bresp_q, bresp_d;
    logic        wlegal_q, wlegal_d, bvalid_q, bvalid_d;

    logic [31:0] tmr_rdata;
    logic        tmr_we;
    logic        ar_legal, aw_legal;

    assign ar_legal = access_legal(BASE_ADDR, araddr, arlen, arsize, arburst);
    assign aw_legal = access_legal(BASE_ADDR, awaddr, awlen, awsize, awburst);
    assign tmr_we   = (w_state_q == W_DATA) && wvalid && wlegal_q;

    clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clock       (clock),
        .reset       (reset),
        .wr_en_i     (tmr_we),
        .wr_sel_i    (wsel_q),
        .wr_data_i   (wdata),
        .wr_strb_i   (wstrb),
        .rd_sel_i    (araddr[3:2]),
        .rd_data_o   (tmr_rdata),
        .timer_irq_o (timer_irq)
    );

    always_comb begin
        r_state_d = r_state_q;
        beats_d   = beats_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    beats_d   = ar_legal ? 9'd1 : {1'b0, arlen} + 9'd1;
                    rid_d     = arid;
                    rdata_d   = ar_legal ? tmr_rdata : 32'd0;
                    rresp_d   = ar_legal ? RESP_OKAY : RESP_SLVERR;
                    rlast_d   = ar_legal || (arlen == 8'd0);
                    rvalid_d  = 1'b1;
                    r_state_d = R_BEAT;
                end
            end
            R_BEAT: begin
                if (rready) begin
                    if (beats_q == 9'd1) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        beats_d = beats_q - 9'd1;
                        rlast_d = (beats_q == 9'd2);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // W beats are only accepted after AW; wlast alone terminates the data phase.
    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        wsel_d    = wsel_q;
        wlegal_d  = wlegal_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    awid_d    = awid;
                    wsel_d    = awaddr[3:2];
                    wlegal_d  = aw_legal;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wlast) begin
                    bvalid_d  = 1'b1;
                    bresp_d   = wlegal_q ? RESP_OKAY : RESP_SLVERR;
                    bid_d     = awid_q;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            beats_q   <= 9'd0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= 4'd0;
            w_state_q <= W_IDLE;
            awid_q    <= 4'd0;
            wsel_q    <= 2'd0;
            wlegal_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= 4'd0;
        end else begin
            r_state_q <= r_state_d;
            beats_q   <= beats_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            wsel_q    <= wsel_d;
            wlegal_q  <= wlegal_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
        end
    end

    assign arready = (r_state_q == R_IDLE);
    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;

endmodule

// File: tb/tb_clint_axi_slave.sv
// Randomized bench for clint_axi_slave against a register-level model of the CLINT timer.
module tb_clint_axi_slave;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int unsigned TDIV = 1;

    logic        clock, reset;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr, rdata;
    logic [3:0]  arid, rid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awid, wstrb, bid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic        timer_irq;

    int n_chk = 0;
    int n_fail = 0;

    clint_axi_slave #(.BASE_ADDR(BASE), .TICK_DIV(TDIV)) dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .timer_irq(timer_irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: four 32-bit words, mtime advancing once per TDIV clocks.
    logic [63:0] m_mtime = 64'd0;
    logic [63:0] m_cmp   = '1;
    int unsigned m_presc = 0;
    logic        mdl_we  = 1'b0;
    logic [1:0]  mdl_sel = 2'd0;
    logic [31:0] mdl_dat = 32'd0;
    logic [3:0]  mdl_strb = 4'd0;
    logic        irq_on  = 1'b0;

    function automatic logic [31:0] put_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_reg(input logic [1:0] sel);
        case (sel)
            2'd0: return m_mtime[31:0];
            2'd1: return m_mtime[63:32];
            2'd2: return m_cmp[31:0];
            default: return m_cmp[63:32];
        endcase
    endfunction

    function automatic logic ref_legal(input logic [31:0] a, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        return (a >= BASE) && (a <= BASE + 32'd12) && (a % 4 == 0) &&
               (len == 8'd0) && (size == 3'd2) && (burst == 2'd1);
    endfunction

    always @(posedge clock or negedge reset) begin
        bit tk;
        if (!reset) begin
            m_mtime = 64'd0;
            m_cmp   = '1;
            m_presc = 0;
        end else begin
            tk = (m_presc == TDIV - 1);
            m_presc = tk ? 0 : m_presc + 1;
            if (mdl_we && mdl_sel == 2'd0)
                m_mtime[31:0] = put_bytes(m_mtime[31:0], mdl_dat, mdl_strb);
            else if (mdl_we && mdl_sel == 2'd1)
                m_mtime[63:32] = put_bytes(m_mtime[63:32], mdl_dat, mdl_strb);
            else if (tk)
                m_mtime = m_mtime + 64'd1;
            if (mdl_we && mdl_sel == 2'd2) m_cmp[31:0]  = put_bytes(m_cmp[31:0], mdl_dat, mdl_strb);
            if (mdl_we && mdl_sel == 2'd3) m_cmp[63:32] = put_bytes(m_cmp[63:32], mdl_dat, mdl_strb);
        end
    end

    always @(negedge clock) if (irq_on) chk("irq", timer_irq, m_mtime >= m_cmp);

    task automatic rd(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int stall,
                      output logic [31:0] first);
        logic lg;
        logic [31:0] ed;
        int nb, to;
        first = 32'd0;
        @(negedge clock);
        to = 0;
        while (!arready && to < 50) begin @(negedge clock); to++; end
        chk("ar_ready", arready, 1'b1);
        araddr = a; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        lg = ref_legal(a, len, size, burst);
        ed = lg ? m_reg(a[3:2]) : 32'd0;
        nb = lg ? 1 : int'(len) + 1;
        @(negedge clock);
        arvalid = 1'b0;
        chk("ar_busy", arready, 1'b0);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k <= stall; k++) begin
                chk("r_valid", rvalid, 1'b1);
                chk("r_data", rdata, ed);
                chk("r_resp", rresp, lg ? 2'b00 : 2'b10);
                chk("r_id", rid, id);
                chk("r_last", rlast, b == nb - 1);
                if (b == 0) first = rdata;
                if (k == stall) rready = 1'b1;
                @(negedge clock);
            end
            rready = 1'b0;
        end
        chk("r_done", rvalid, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst,
                      input logic [31:0] d, input logic [3:0] s, input int stall);
        logic lg;
        int nb, to;
        @(negedge clock);
        to = 0;
        while (!awready && to < 50) begin @(negedge clock); to++; end
        chk("aw_ready", awready, 1'b1);
        chk("w_idle_nrdy", wready, 1'b0);
        awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        lg = ref_legal(a, len, size, burst);
        nb = int'(len) + 1;
        @(negedge clock);
        awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            chk("w_ready", wready, 1'b1);
            wvalid = 1'b1;
            wdata  = (b == 0) ? d : $urandom;
            wstrb  = (b == 0) ? s : 4'($urandom);
            wlast  = (b == nb - 1);
            mdl_we = lg; mdl_sel = a[3:2]; mdl_dat = wdata; mdl_strb = wstrb;
            @(negedge clock);
            mdl_we = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        end
        for (int k = 0; k <= stall; k++) begin
            chk("b_valid", bvalid, 1'b1);
            chk("b_resp", bresp, lg ? 2'b00 : 2'b10);
            chk("b_id", bid, id);
            chk("w_resp_nrdy", wready, 1'b0);
            if (k == stall) bready = 1'b1;
            @(negedge clock);
        end
        bready = 1'b0;
        chk("b_done", bvalid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [31:0] v, a;
        logic [63:0] cmp_exp;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int to;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_arready", arready, 1'b1);
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", rresp, 2'd0);
        chk("rst_rid", rid, 4'd0);
        chk("rst_bid", bid, 4'd0);
        chk("rst_bresp", bresp, 2'd0);
        chk("rst_irq", timer_irq, 1'b0);
        irq_on = 1'b1;
        reset = 1'b1;
        repeat (10) @(negedge clock);

        rd(BASE, 4'd5, 8'd0, 3'd2, 2'd1, 0, v);
        wr(BASE + 32'd4, 4'd3, 8'd0, 3'd2, 2'd1, 32'hDEAD_BEEF, 4'b0011, 0);
        rd(BASE + 32'd4, 4'd1, 8'd0, 3'd2, 2'd1, 0, v);
        chk("mtime_hi_beef", v, 32'h0000_BEEF);

        wr(BASE + 32'd4, 4'd2, 8'd0, 3'd2, 2'd1, 32'd0, 4'hF, 0);
        cmp_exp = {32'd0, m_mtime[31:0] + 32'd40};
        wr(BASE + 32'd8, 4'd4, 8'd0, 3'd2, 2'd1, cmp_exp[31:0], 4'hF, 0);
        wr(BASE + 32'd12, 4'd6, 8'd0, 3'd2, 2'd1, 32'd0, 4'hF, 0);
        chk("irq_low_before", timer_irq, 1'b0);
        to = 0;
        while (!timer_irq && to < 200) begin @(negedge clock); to++; end
        chk("irq_rise", timer_irq, 1'b1);
        chk("irq_at_cmp", m_mtime, cmp_exp);
        wr(BASE + 32'd12, 4'd7, 8'd0, 3'd2, 2'd1, 32'hFFFF_FFFF, 4'hF, 0);
        chk("irq_cleared", timer_irq, 1'b0);

        rd(BASE + 32'h10, 4'd9, 8'd3, 3'd2, 2'd1, 1, v);
        rd(BASE + 32'h8, 4'd10, 8'd0, 3'd2, 2'd1, 0, v);
        wr(BASE + 32'd2, 4'd11, 8'd0, 3'd2, 2'd1, 32'h1234_5678, 4'hF, 5);
        rd(BASE + 32'h8, 4'd12, 8'd0, 3'd2, 2'd1, 5, v);
        chk("cmp_lo_kept", v, cmp_exp[31:0]);
        rd(BASE + 32'hC, 4'd13, 8'd0, 3'd2, 2'd1, 0, v);
        chk("cmp_hi_kept", v, 32'hFFFF_FFFF);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: a = BASE + 32'(4 * $urandom_range(0, 3));
                4:          a = BASE + 32'd2;
                5:          a = BASE + 32'h10;
                6:          a = $urandom;
                default:    a = BASE + 32'(4 * $urandom_range(0, 3)) + 32'd1;
            endcase
            len   = ($urandom_range(0, 9) < 8) ? 8'd0 : 8'($urandom_range(1, 3));
            size  = ($urandom_range(0, 9) < 9) ? 3'd2 : 3'($urandom);
            burst = ($urandom_range(0, 9) < 9) ? 2'd1 : 2'($urandom);
            if ($urandom_range(0, 1) == 0)
                rd(a, 4'($urandom), len, size, burst, $urandom_range(0, 2), v);
            else
                wr(a, 4'($urandom), len, size, burst, $urandom, 4'($urandom), $urandom_range(0, 2));
        end

        @(negedge clock);
        araddr = BASE + 32'h10; arid = 4'd9; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1;
        arvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0;
        chk("mid_rvalid", rvalid, 1'b1);
        rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;
        chk("mid_rlast", rlast, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_rvalid", rvalid, 1'b0);
        chk("rst_mid_rid", rid, 4'd0);
        chk("rst_mid_arready", arready, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_arready", arready, 1'b1);
        rd(BASE, 4'd1, 8'd0, 3'd2, 2'd1, 0, v);
        chk("post_rst_mtime_small", v < 32'd10, 1'b1);
        rd(BASE + 32'hC, 4'd2, 8'd0, 3'd2, 2'd1, 0, v);
        chk("post_rst_cmp_hi", v, 32'hFFFF_FFFF);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
